// File: rtl/pc_sequencer_pkg.sv
// Shared types and defaults for the fetch sequencer and its timeout timer.
package pc_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOADVEC = 3'd1,
    S_FETCH   = 3'd2,
    S_ISSUE   = 3'd3,
    S_HALT    = 3'd4,
    S_FAULT   = 3'd5
  } state_t;

  localparam logic [15:0] DEF_RESET_VEC = 16'h0000;
  localparam int          DEF_TIMEOUT   = 8;

  function automatic int timer_w(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/pc_sequencer_fetch_timer.sv
// Fetch timeout down-counter: reloads to TIMEOUT on clear, flags the last allowed cycle.
module pc_sequencer_fetch_timer #(
  parameter int TIMEOUT = 8,
  parameter int W       = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= W'(TIMEOUT);
    end else if (clr) begin
      cnt <= W'(TIMEOUT);
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  // terminal count: this enabled cycle is the TIMEOUT-th without an ack
  assign expired = en && (cnt == W'(1));

endmodule

// File: rtl/pc_sequencer.sv
// Fetch sequencer: drives pc load/inc, instruction-memory reads and the ir valid/ready register.
//   state   | meaning
//   IDLE    | waiting for start after reset
//   LOADVEC | loading RESET_VEC into pc
//   FETCH   | reading imem at pc_val, timeout running
//   ISSUE   | ir valid, waiting for decode ready
//   HALT    | stopped, start resumes at pc_val
//   FAULT   | fetch timed out, start reloads vector
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int                ADDR_W    = 16,
  parameter int                DATA_W    = 16,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(DEF_RESET_VEC),
  parameter int                TIMEOUT   = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              halt_req,
  input  logic [ADDR_W-1:0] pc_val,
  output logic [ADDR_W-1:0] pc_in,
  output logic              pc_load,
  output logic              pc_inc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] ir,
  output logic              ir_valid,
  input  logic              ir_ready,
  input  logic              br_take,
  input  logic [ADDR_W-1:0] br_target,
  output logic [15:0]       icount,
  output logic              halted,
  output logic              fault
);

  localparam int TW = timer_w(TIMEOUT);

  state_t state, state_nx;
  logic   halt_pend;
  logic   ir_ld;
  logic   issue_hs;
  logic   tmr_clr;
  logic   tmr_en;
  logic   tmr_expired;

  assign tmr_en  = (state == S_FETCH);
  assign tmr_clr = (state != S_FETCH) || imem_ack;

  pc_sequencer_fetch_timer #(
    .TIMEOUT (TIMEOUT),
    .W       (TW)
  ) u_fetch_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (tmr_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    pc_in     = '0;
    pc_load   = 1'b0;
    pc_inc    = 1'b0;
    imem_req  = 1'b0;
    imem_addr = '0;
    ir_ld     = 1'b0;
    issue_hs  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nx = S_LOADVEC;
      end
      S_LOADVEC: begin
        pc_load  = 1'b1;
        pc_in    = RESET_VEC;
        state_nx = S_FETCH;
      end
      S_FETCH: begin
        imem_req  = 1'b1;
        imem_addr = pc_val;
        // ack wins over a coincident timeout
        if (imem_ack) begin
          ir_ld    = 1'b1;
          pc_inc   = 1'b1;
          state_nx = S_ISSUE;
        end else if (tmr_expired) begin
          state_nx = S_FAULT;
        end
      end
      S_ISSUE: begin
        if (ir_ready) begin
          issue_hs = 1'b1;
          if (br_take) begin
            pc_load = 1'b1;
            pc_in   = br_target;
          end
          state_nx = (halt_pend || halt_req) ? S_HALT : S_FETCH;
        end
      end
      S_HALT: begin
        if (start) state_nx = S_FETCH;
      end
      S_FAULT: begin
        if (start) state_nx = S_LOADVEC;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ir        <= '0;
      icount    <= '0;
      halt_pend <= 1'b0;
    end else begin
      if (ir_ld) ir <= imem_rdata;
      if (issue_hs) icount <= icount + 16'd1;
      // a stale halt request must not survive into the next run
      if ((state_nx == S_HALT) || (state_nx == S_FAULT)) begin
        halt_pend <= 1'b0;
      end else if (halt_req && ((state == S_FETCH) || (state == S_ISSUE))) begin
        halt_pend <= 1'b1;
      end
    end
  end

  assign ir_valid = (state == S_ISSUE);
  assign halted   = (state == S_HALT);
  assign fault    = (state == S_FAULT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a behavioural pc register alongside.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        halt_req = 1'b0;
  logic [15:0] pc_val;
  logic [15:0] pc_in;
  logic        pc_load;
  logic        pc_inc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = 16'h0000;
  logic [15:0] ir;
  logic        ir_valid;
  logic        ir_ready = 1'b0;
  logic        br_take = 1'b0;
  logic [15:0] br_target = 16'h0000;
  logic [15:0] icount;
  logic        halted;
  logic        fault;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .halt_req   (halt_req),
    .pc_val     (pc_val),
    .pc_in      (pc_in),
    .pc_load    (pc_load),
    .pc_inc     (pc_inc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .ir         (ir),
    .ir_valid   (ir_valid),
    .ir_ready   (ir_ready),
    .br_take    (br_take),
    .br_target  (br_target),
    .icount     (icount),
    .halted     (halted),
    .fault      (fault)
  );

  // external pc register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc_val <= 16'hAAAA;
    else if (pc_load) pc_val <= pc_in;
    else if (pc_inc) pc_val <= pc_val + 16'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_fetch(input logic [15:0] addr, input logic [15:0] data);
    chk("fetch_req", {31'd0, imem_req}, 32'd1);
    chk("fetch_addr", {16'd0, imem_addr}, {16'd0, addr});
    imem_ack   = 1'b1;
    imem_rdata = data;
    #1;
    chk("fetch_inc", {30'd0, pc_inc, pc_load}, 32'd2);
    tick();
    imem_ack = 1'b0;
    #1;
    chk("fetch_ir", {16'd0, ir}, {16'd0, data});
    chk("fetch_valid", {30'd0, ir_valid, imem_req}, 32'd2);
  endtask

  task automatic do_issue(input logic br, input logic [15:0] tgt);
    ir_ready  = 1'b1;
    br_take   = br;
    br_target = tgt;
    #1;
    chk("issue_load", {30'd0, pc_load, pc_inc}, {30'd0, br, 1'b0});
    if (br) chk("issue_pc_in", {16'd0, pc_in}, {16'd0, tgt});
    tick();
    ir_ready = 1'b0;
    br_take  = 1'b0;
  endtask

  initial begin
    // reset state
    @(negedge clk);
    chk("rst_ctl", {27'd0, pc_load, pc_inc, imem_req, halted, fault}, 32'd0);
    chk("rst_pc_in", {16'd0, pc_in}, 32'd0);
    chk("rst_ir", {15'd0, ir, ir_valid}, 32'd0);
    chk("rst_icount", {16'd0, icount}, 32'd0);

    // start -> LOADVEC -> FETCH
    rst   = 1'b1;
    start = 1'b1;
    #1;
    chk("idle_no_load", {31'd0, pc_load}, 32'd0);
    tick();
    start = 1'b0;
    #1;
    chk("loadvec", {14'd0, pc_load, pc_inc, pc_in}, {14'd0, 2'b10, 16'h0000});
    tick();
    do_fetch(16'h0000, 16'h1234);
    chk("pc_after_first", {16'd0, pc_val}, 32'h0001);
    do_issue(1'b0, 16'h0);

    // back-to-back fetches, two cycles each
    do_fetch(16'h0001, 16'hA001);
    do_issue(1'b0, 16'h0);
    do_fetch(16'h0002, 16'hA002);
    do_issue(1'b0, 16'h0);
    chk("icount3", {16'd0, icount}, 32'd3);

    // halt request during FETCH at 0003
    halt_req = 1'b1;
    do_fetch(16'h0003, 16'h5555);
    halt_req = 1'b0;
    chk("not_halted_yet", {31'd0, halted}, 32'd0);
    do_issue(1'b0, 16'h0);
    chk("halted", {30'd0, halted, imem_req}, 32'd2);
    chk("halt_pc", {16'd0, pc_val}, 32'h0004);
    chk("icount4", {16'd0, icount}, 32'd4);
    tick();
    chk("halt_sticky", {31'd0, halted}, 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("resume", {31'd0, halted}, 32'd0);
    do_fetch(16'h0004, 16'h0404);
    do_issue(1'b0, 16'h0);

    // branch on handshake at 0005
    do_fetch(16'h0005, 16'h0505);
    do_issue(1'b1, 16'h0040);
    chk("br_addr", {16'd0, imem_addr}, 32'h0040);
    chk("icount6", {16'd0, icount}, 32'd6);

    // branch and halt together: branch commits, then halt
    do_fetch(16'h0040, 16'h4040);
    halt_req = 1'b1;
    do_issue(1'b1, 16'h0100);
    halt_req = 1'b0;
    chk("br_halt", {31'd0, halted}, 32'd1);
    chk("br_halt_pc", {16'd0, pc_val}, 32'h0100);
    chk("icount7", {16'd0, icount}, 32'd7);
    start = 1'b1;
    tick();
    start = 1'b0;

    // decode stalls for 5 cycles
    do_fetch(16'h0100, 16'hBEEF);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_ir", {16'd0, ir}, 32'h0000BEEF);
      chk("stall_flags", {30'd0, ir_valid, imem_req}, 32'd2);
      chk("stall_icount", {16'd0, icount}, 32'd7);
    end

    // async reset mid-ISSUE
    rst = 1'b0;
    #1;
    chk("rst_issue_flags", {28'd0, ir_valid, imem_req, pc_load, pc_inc}, 32'd0);
    chk("rst_issue_regs", {ir, icount}, 32'd0);
    tick();
    rst = 1'b1;

    // fetch timeout
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    for (int i = 1; i <= 8; i++) begin
      chk("to_wait", {30'd0, imem_req, fault}, 32'd2);
      tick();
    end
    chk("to_fault", {30'd0, fault, imem_req}, 32'd2);
    tick();
    chk("fault_sticky", {31'd0, fault}, 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    #1;
    chk("fault_reload", {15'd0, pc_load, pc_in}, {15'd0, 1'b1, 16'h0000});
    tick();

    // ack on the last allowed cycle beats expiry
    repeat (7) tick();
    do_fetch(16'h0000, 16'h7777);
    chk("ack_wins", {31'd0, fault}, 32'd0);
    do_issue(1'b0, 16'h0);

    // async reset mid-FETCH with an ack pending
    chk("pre_rst_req", {31'd0, imem_req}, 32'd1);
    imem_ack   = 1'b1;
    imem_rdata = 16'hDEAD;
    rst        = 1'b0;
    #1;
    chk("rst_fetch", {15'd0, imem_req, imem_addr}, 32'd0);
    chk("rst_fetch_inc", {31'd0, pc_inc}, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    chk("ack_ignored", {15'd0, ir, ir_valid}, 32'd0);
    chk("idle_after_rst", {31'd0, imem_req}, 32'd0);
    imem_ack = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
